// File: rtl/ariscv_pkg.sv
// Shared integer register file definitions: widths, the x0 address and the
// address/word types used by rf_m and the write-back path.
package ariscv_pkg;

    localparam int XLEN = 32;
    localparam int MSB  = 4;

    typedef logic [MSB:0]    reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_addr_t ZERO = '0;

endpackage

// File: rtl/rf_bypass_m.sv
// Read-port forwarding mux: returns the in-flight write-back value when it
// targets the register being read, otherwise the raw register file data.
module rf_bypass_m #(
    parameter int XLEN = ariscv_pkg::XLEN,
    parameter int MSB  = ariscv_pkg::MSB
) (
    input  logic            we3,
    input  logic [MSB:0]    a3,
    input  logic [XLEN-1:0] wd3,
    input  logic [MSB:0]    ra,
    input  logic [XLEN-1:0] rf_rd,
    output logic [XLEN-1:0] rd
);

    // x0 never forwards; the file already forces it to zero.
    always_comb begin
        rd = rf_rd;
        if (we3 && (a3 == ra) && (|ra)) begin
            rd = wd3;
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Write-back arbiter: round-robin share of the register file write port
// between ALU (0) and LSU (1), registered write, read bypass, stall counters.
module rf_wb_arb #(
    parameter int XLEN = ariscv_pkg::XLEN,
    parameter int MSB  = ariscv_pkg::MSB,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            hold,
    input  logic            clr_stats,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [MSB:0]    req0_addr,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [MSB:0]    req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            we3,
    output logic [MSB:0]    a3,
    output logic [XLEN-1:0] wd3,
    input  logic [MSB:0]    ra1,
    input  logic [MSB:0]    ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [CNTW-1:0] stall0,
    output logic [CNTW-1:0] stall1
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]      valid_vec;
    logic [1:0]      grant_vec;
    logic            prio_reg;
    logic [MSB:0]    win_addr;
    logic [XLEN-1:0] win_data;
    logic [CNTW-1:0] stall_cnt_reg [2];

    assign valid_vec = {req1_valid, req0_valid};

    // prio only matters when both requesters are valid.
    assign grant_vec[0] = ~srst & ~hold & valid_vec[0] & (~valid_vec[1] | ~prio_reg);
    assign grant_vec[1] = ~srst & ~hold & valid_vec[1] & (~valid_vec[0] |  prio_reg);

    assign req0_ready = grant_vec[0];
    assign req1_ready = grant_vec[1];

    assign win_addr = grant_vec[1] ? req1_addr : req0_addr;
    assign win_data = grant_vec[1] ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (srst) begin
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            prio_reg <= 1'b0;
        end else if (|grant_vec) begin
            we3      <= |win_addr;
            a3       <= win_addr;
            wd3      <= win_data;
            prio_reg <= grant_vec[0];
        end else begin
            we3      <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stall
            always_ff @(posedge clk) begin
                if (srst || clr_stats) begin
                    stall_cnt_reg[gi] <= '0;
                end else if (valid_vec[gi] && !grant_vec[gi] && !(&stall_cnt_reg[gi])) begin
                    stall_cnt_reg[gi] <= stall_cnt_reg[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign stall0 = stall_cnt_reg[0];
    assign stall1 = stall_cnt_reg[1];

    rf_bypass_m #(.XLEN(XLEN), .MSB(MSB)) u_byp1 (
        .we3   (we3),
        .a3    (a3),
        .wd3   (wd3),
        .ra    (ra1),
        .rf_rd (rf_rd1),
        .rd    (rd1)
    );

    rf_bypass_m #(.XLEN(XLEN), .MSB(MSB)) u_byp2 (
        .we3   (we3),
        .a3    (a3),
        .wd3   (wd3),
        .ra    (ra2),
        .rf_rd (rf_rd2),
        .rd    (rd2)
    );

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_rf_wb_arb;

    localparam int XLEN = 32;
    localparam int MSB  = 4;
    localparam int CNTW = 2;
    localparam int SAT  = (1 << CNTW) - 1;

    logic                clk = 1'b0;
    logic                srst = 1'b1;
    logic                hold = 1'b0;
    logic                clr_stats = 1'b0;
    logic                req0_valid = 1'b0, req1_valid = 1'b0;
    logic                req0_ready, req1_ready;
    logic [MSB:0]        req0_addr = '0, req1_addr = '0;
    ariscv_pkg::word_t   req0_data = '0, req1_data = '0;
    logic                we3;
    logic [MSB:0]        a3;
    logic [XLEN-1:0]     wd3;
    logic [MSB:0]        ra1 = '0, ra2 = '0;
    logic [XLEN-1:0]     rf_rd1 = '0, rf_rd2 = '0;
    logic [XLEN-1:0]     rd1, rd2;
    logic [CNTW-1:0]     stall0, stall1;

    rf_wb_arb #(.XLEN(XLEN), .MSB(MSB), .CNTW(CNTW)) dut (
        .clk        (clk),
        .srst       (srst),
        .hold       (hold),
        .clr_stats  (clr_stats),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .we3        (we3),
        .a3         (a3),
        .wd3        (wd3),
        .ra1        (ra1),
        .ra2        (ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .rd1        (rd1),
        .rd2        (rd2),
        .stall0     (stall0),
        .stall1     (stall1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: last pending write, whose turn it is, and stall totals.
    bit              m_we = 0;
    logic [MSB:0]    m_a3 = '0;
    logic [XLEN-1:0] m_wd3 = '0;
    int              m_turn = 0;
    int              m_stall [2] = '{0, 0};
    bit              acc0 = 0, acc1 = 0;
    bit              done = 0;

    initial begin
        @(posedge clk);
        while (!done) begin
            bit g0, g1;
            logic [XLEN-1:0] e1, e2;
            @(negedge clk);
            g0 = 0; g1 = 0;
            if (!srst && !hold) begin
                if (req0_valid && req1_valid) begin
                    g0 = (m_turn == 0);
                    g1 = (m_turn == 1);
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            e1 = (m_we && m_a3 == ra1 && ra1 != 0) ? m_wd3 : rf_rd1;
            e2 = (m_we && m_a3 == ra2 && ra2 != 0) ? m_wd3 : rf_rd2;
            check("req0_ready", req0_ready, g0);
            check("req1_ready", req1_ready, g1);
            check("we3", we3, m_we);
            check("a3", a3, m_a3);
            check("wd3", wd3, m_wd3);
            check("rd1", rd1, e1);
            check("rd2", rd2, e2);
            check("stall0", stall0, m_stall[0]);
            check("stall1", stall1, m_stall[1]);
            acc0 = g0;
            acc1 = g1;
            if (srst) begin
                m_we = 0; m_a3 = '0; m_wd3 = '0; m_turn = 0;
                m_stall[0] = 0; m_stall[1] = 0;
            end else begin
                m_we = 0;
                if (g0 || g1) begin
                    m_a3   = g0 ? req0_addr : req1_addr;
                    m_wd3  = g0 ? req0_data : req1_data;
                    m_we   = (m_a3 != 0);
                    m_turn = g0 ? 1 : 0;
                end
                if (clr_stats) begin
                    m_stall[0] = 0; m_stall[1] = 0;
                end else begin
                    if (req0_valid && !g0 && m_stall[0] < SAT) m_stall[0]++;
                    if (req1_valid && !g1 && m_stall[1] < SAT) m_stall[1]++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    initial begin
        // Reset with both requesters waiting.
        req0_valid = 1; req0_addr = 1; req0_data = 32'haaaa0001;
        req1_valid = 1; req1_addr = 2; req1_data = 32'hbbbb0002;
        for (int i = 0; i < 3; i++) begin
            nedge();
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_we3", we3, 0);
            check("rst_stall0", stall0, 0);
            check("rst_stall1", stall1, 0);
            cyc();
        end
        srst = 0;
        nedge();
        check("first_grant0", req0_ready, 1);
        check("first_grant1", req1_ready, 0);
        cyc();
        req0_valid = 0;
        nedge();
        check("second_grant1", req1_ready, 1);
        check("first_we3", we3, 1);
        check("first_a3", a3, 1);
        cyc();
        req1_valid = 0;

        // Single requester with bypass.
        req0_valid = 1; req0_addr = 5; req0_data = 32'hcafebabe;
        ra1 = 0; rf_rd1 = 32'h11111111;
        nedge();
        check("single_ready0", req0_ready, 1);
        cyc();
        req0_valid = 0; ra1 = 5;
        nedge();
        check("single_we3", we3, 1);
        check("single_a3", a3, 5);
        check("single_wd3", wd3, 32'hcafebabe);
        check("single_rd1", rd1, 32'hcafebabe);
        cyc();

        // x0 write from requester 1.
        req1_valid = 1; req1_addr = 0; req1_data = 32'hffffffff;
        ra2 = 0; rf_rd2 = 0;
        nedge();
        check("x0_ready1", req1_ready, 1);
        cyc();
        req1_valid = 0;
        nedge();
        check("x0_we3", we3, 0);
        check("x0_rd2", rd2, 0);
        cyc();
        clr_stats = 1;
        cyc();
        clr_stats = 0;

        // Contention: both requesters valid for four cycles.
        req0_valid = 1; req0_addr = 1; req0_data = 32'h00000101;
        req1_valid = 1; req1_addr = 2; req1_data = 32'h00000202;
        for (int i = 0; i < 4; i++) begin
            nedge();
            check("cont_ready0", req0_ready, (i % 2) == 0);
            check("cont_ready1", req1_ready, (i % 2) == 1);
            cyc();
        end
        req0_valid = 0; req1_valid = 0;
        nedge();
        check("cont_stall0", stall0, 2);
        check("cont_stall1", stall1, 2);
        cyc();

        // hold blocks grants; counter saturates; clear beats increment.
        clr_stats = 1;
        cyc();
        clr_stats = 0; hold = 1;
        req0_valid = 1; req0_addr = 3; req0_data = 32'h33333333;
        for (int i = 0; i < 5; i++) begin
            nedge();
            check("hold_ready0", req0_ready, 0);
            cyc();
        end
        nedge();
        check("hold_sat_stall0", stall0, 3);
        cyc();
        clr_stats = 1;
        nedge();
        cyc();
        clr_stats = 0; hold = 0;
        nedge();
        check("clr_stall0", stall0, 0);
        check("unhold_ready0", req0_ready, 1);
        cyc();
        req0_valid = 0;

        // Reset mid-stream.
        req0_valid = 1; req0_addr = 7; req0_data = 32'h77777777;
        nedge();
        check("mid_ready0", req0_ready, 1);
        cyc();
        srst = 1; req0_valid = 0;
        req1_valid = 1; req1_addr = 9; req1_data = 32'h99999999;
        nedge();
        check("mid_rst_ready1", req1_ready, 0);
        cyc();
        srst = 0;
        nedge();
        check("mid_lost_we3", we3, 0);
        check("mid_after_ready1", req1_ready, 1);
        cyc();
        req1_valid = 0;
        nedge();
        check("mid_a3", a3, 9);
        cyc();

        // Randomized traffic honouring the valid/ready hold rule.
        for (int n = 0; n < 3000; n++) begin
            srst      = ($urandom_range(0, 99) == 0);
            hold      = ($urandom_range(0, 9) == 0);
            clr_stats = ($urandom_range(0, 19) == 0);
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_addr  = MSB'($urandom_range(0, 7));
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr  = MSB'($urandom_range(0, 7));
                req1_data  = $urandom;
            end
            ra1    = MSB'($urandom_range(0, 7));
            ra2    = MSB'($urandom_range(0, 7));
            rf_rd1 = $urandom;
            rf_rd2 = $urandom;
            cyc();
        end
        srst = 0; hold = 0; clr_stats = 0;
        req0_valid = 0; req1_valid = 0;
        cyc();
        done = 1;
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
